// File: rtl/alu_arbiter_if.sv
// Request/response channels of both requesters plus the shared ALU connection.
// The arbiter uses the slave modport; requesters and the ALU model sit on the master side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid_i;
  logic             req1_valid_i;
  logic             req0_ready_o;
  logic             req1_ready_o;
  logic [2:0]       req0_op_i;
  logic [2:0]       req1_op_i;
  logic [WIDTH-1:0] req0_a_i;
  logic [WIDTH-1:0] req1_a_i;
  logic [WIDTH-1:0] req0_b_i;
  logic [WIDTH-1:0] req1_b_i;
  logic             rsp0_valid_o;
  logic             rsp1_valid_o;
  logic             rsp0_ready_i;
  logic             rsp1_ready_i;
  logic [WIDTH-1:0] rsp0_result_o;
  logic [WIDTH-1:0] rsp1_result_o;
  logic             rsp0_zero_o;
  logic             rsp1_zero_o;
  logic [WIDTH-1:0] alu_a_o;
  logic [WIDTH-1:0] alu_b_o;
  logic [2:0]       alu_ctrl_o;
  logic [WIDTH-1:0] alu_result_i;
  logic             alu_zero_i;
  logic             busy_o;
  logic             owner_o;

  modport slave (
    input  req0_valid_i, req1_valid_i, req0_op_i, req1_op_i,
           req0_a_i, req1_a_i, req0_b_i, req1_b_i,
           rsp0_ready_i, rsp1_ready_i, alu_result_i, alu_zero_i,
    output req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o,
           rsp0_result_o, rsp1_result_o, rsp0_zero_o, rsp1_zero_o,
           alu_a_o, alu_b_o, alu_ctrl_o, busy_o, owner_o
  );

  modport master (
    output req0_valid_i, req1_valid_i, req0_op_i, req1_op_i,
           req0_a_i, req1_a_i, req0_b_i, req1_b_i,
           rsp0_ready_i, rsp1_ready_i, alu_result_i, alu_zero_i,
    input  req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o,
           rsp0_result_o, rsp1_result_o, rsp0_zero_o, rsp1_zero_o,
           alu_a_o, alu_b_o, alu_ctrl_o, busy_o, owner_o
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters, granting round-robin
// (or fixed priority) and returning the registered result to whoever issued the op.
module alu_arbiter #(
  parameter int WIDTH      = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic         clk_i,
  input logic         rst_n_i,
  alu_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             ptr;
  logic             owner;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  logic             winner;
  logic             any_valid;
  logic             accept;
  logic             rsp_done;

  // Winner is only meaningful while some request is valid; ptr names the tie-break winner.
  always_comb begin
    any_valid = bus.req0_valid_i | bus.req1_valid_i;
    winner    = bus.req1_valid_i;
    if (bus.req0_valid_i && bus.req1_valid_i) begin
      winner = FIXED_PRIO ? 1'b0 : ptr;
    end
  end

  assign accept   = (state == IDLE) && any_valid;
  assign rsp_done = (state == RESP) && (owner ? bus.rsp1_ready_i : bus.rsp0_ready_i);

  // Ready is gated by reset so nothing is offered while the block is held in reset.
  assign bus.req0_ready_o = rst_n_i && accept && !winner;
  assign bus.req1_ready_o = rst_n_i && accept && winner;

  assign bus.rsp0_valid_o  = (state == RESP) && !owner;
  assign bus.rsp1_valid_o  = (state == RESP) && owner;
  assign bus.rsp0_result_o = result_q;
  assign bus.rsp1_result_o = result_q;
  assign bus.rsp0_zero_o   = zero_q;
  assign bus.rsp1_zero_o   = zero_q;

  assign bus.alu_a_o    = a_q;
  assign bus.alu_b_o    = b_q;
  assign bus.alu_ctrl_o = op_q;
  assign bus.busy_o     = (state != IDLE);
  assign bus.owner_o    = owner;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      owner    <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= winner ? bus.req1_op_i : bus.req0_op_i;
            a_q   <= winner ? bus.req1_a_i  : bus.req0_a_i;
            b_q   <= winner ? bus.req1_b_i  : bus.req0_b_i;
            owner <= winner;
            state <= EXEC;
          end
        end
        EXEC: begin
          result_q <= bus.alu_result_i;
          zero_q   <= bus.alu_zero_i;
          state    <= RESP;
        end
        RESP: begin
          // The requester just served loses the next tie.
          if (rsp_done) begin
            state <= IDLE;
            if (!FIXED_PRIO) begin
              ptr <= ~owner;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, hand-written multi-cycle sequences and a
// randomized run checked against a transaction-level model of the arbitration rules.
module tb_alu_arbiter;
  localparam int WIDTH = 32;

  typedef struct {
    bit               req;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  vec_t vecs [14];

  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();
  alu_arbiter_if #(.WIDTH(WIDTH)) fbus ();

  alu_arbiter #(.WIDTH(WIDTH), .FIXED_PRIO(1'b0)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  alu_arbiter #(.WIDTH(WIDTH), .FIXED_PRIO(1'b1)) dut_fixed (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (fbus)
  );

  function automatic logic [WIDTH-1:0] alu_ref(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return {{(WIDTH-1){1'b0}}, (a < b)};
      3'b110:  return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  // The ALU itself lives outside the arbiter, so the bench supplies it.
  assign bus.alu_result_i  = alu_ref(bus.alu_ctrl_o, bus.alu_a_o, bus.alu_b_o);
  assign bus.alu_zero_i    = (bus.alu_result_i == '0);
  assign fbus.alu_result_i = alu_ref(fbus.alu_ctrl_o, fbus.alu_a_o, fbus.alu_b_o);
  assign fbus.alu_zero_i   = (fbus.alu_result_i == '0);

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checkOutput(name, {{(WIDTH-1){1'b0}}, actual}, {{(WIDTH-1){1'b0}}, expected});
  endtask

  task automatic drive_req(input bit r, input logic v, input logic [2:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (r) begin
      bus.req1_valid_i = v; bus.req1_op_i = op; bus.req1_a_i = a; bus.req1_b_i = b;
    end else begin
      bus.req0_valid_i = v; bus.req0_op_i = op; bus.req0_a_i = a; bus.req0_b_i = b;
    end
  endtask

  task automatic set_rsp_ready(input bit r, input logic v);
    if (r) bus.rsp1_ready_i = v;
    else   bus.rsp0_ready_i = v;
  endtask

  task automatic idle_inputs();
    drive_req(1'b0, 1'b0, 3'b000, '0, '0);
    drive_req(1'b1, 1'b0, 3'b000, '0, '0);
    bus.rsp0_ready_i  = 1'b0; bus.rsp1_ready_i  = 1'b0;
    fbus.req0_valid_i = 1'b0; fbus.req1_valid_i = 1'b0;
    fbus.req0_op_i    = '0;   fbus.req1_op_i    = '0;
    fbus.req0_a_i     = '0;   fbus.req1_a_i     = '0;
    fbus.req0_b_i     = '0;   fbus.req1_b_i     = '0;
    fbus.rsp0_ready_i = 1'b0; fbus.rsp1_ready_i = 1'b0;
  endtask

  function automatic logic ready_of(input bit r);
    return r ? bus.req1_ready_o : bus.req0_ready_o;
  endfunction

  function automatic logic rsp_valid_of(input bit r);
    return r ? bus.rsp1_valid_o : bus.rsp0_valid_o;
  endfunction

  function automatic logic [WIDTH-1:0] rsp_result_of(input bit r);
    return r ? bus.rsp1_result_o : bus.rsp0_result_o;
  endfunction

  function automatic logic rsp_zero_of(input bit r);
    return r ? bus.rsp1_zero_o : bus.rsp0_zero_o;
  endfunction

  // One complete transaction from an idle arbiter: accept, EXEC, RESP with immediate ready.
  task automatic applyStimulus(input vec_t v, input string name);
    @(negedge clk);
    drive_req(v.req, 1'b1, v.op, v.a, v.b);
    #1;
    checkBit({name, " accept"}, ready_of(v.req), 1'b1);
    checkBit({name, " other ready"}, ready_of(!v.req), 1'b0);
    @(negedge clk);
    drive_req(v.req, 1'b0, 3'b000, '0, '0);
    #1;
    checkBit({name, " exec busy"}, bus.busy_o, 1'b1);
    checkBit({name, " exec rsp_valid"}, rsp_valid_of(v.req), 1'b0);
    @(negedge clk);
    #1;
    checkBit({name, " rsp_valid"}, rsp_valid_of(v.req), 1'b1);
    checkBit({name, " other rsp_valid"}, rsp_valid_of(!v.req), 1'b0);
    checkOutput({name, " result"}, rsp_result_of(v.req), v.result);
    checkBit({name, " zero"}, rsp_zero_of(v.req), v.zero);
    checkBit({name, " owner"}, bus.owner_o, v.req);
    set_rsp_ready(v.req, 1'b1);
    @(negedge clk);
    set_rsp_ready(v.req, 1'b0);
    #1;
    checkBit({name, " done busy"}, bus.busy_o, 1'b0);
    checkBit({name, " done rsp_valid"}, rsp_valid_of(v.req), 1'b0);
  endtask

  initial begin
    bit               pend [2];
    logic [2:0]       rop  [2];
    logic [WIDTH-1:0] ra   [2];
    logic [WIDTH-1:0] rb   [2];
    bit               rrdy [2];
    bit               exp_r [2];
    bit               outstanding;
    bit               out_owner;
    bit               tie_winner;
    bit               w;
    bit               g;
    int               age;
    logic [WIDTH-1:0] out_res;
    vec_t             v;

    vecs[0]  = '{1'b0, 3'b000, 32'd5,         32'd7,      32'd12,        1'b0};
    vecs[1]  = '{1'b1, 3'b001, 32'h10,        32'h10,     32'd0,         1'b1};
    vecs[2]  = '{1'b0, 3'b110, 32'd1,         32'd4,      32'd16,        1'b0};
    vecs[3]  = '{1'b1, 3'b111, 32'h80,        32'd3,      32'd16,        1'b0};
    vecs[4]  = '{1'b0, 3'b100, 32'hFF,        32'h0F,     32'hF0,        1'b0};
    vecs[5]  = '{1'b1, 3'b101, 32'd3,         32'd9,      32'd1,         1'b0};
    vecs[6]  = '{1'b0, 3'b101, 32'd9,         32'd3,      32'd0,         1'b1};
    vecs[7]  = '{1'b1, 3'b010, 32'hF0F0,      32'h0FF0,   32'h00F0,      1'b0};
    vecs[8]  = '{1'b0, 3'b011, 32'h100,       32'h001,    32'h101,       1'b0};
    vecs[9]  = '{1'b1, 3'b001, 32'd0,         32'd1,      32'hFFFFFFFF,  1'b0};
    vecs[10] = '{1'b0, 3'b000, 32'hFFFFFFFF,  32'd1,      32'd0,         1'b1};
    vecs[11] = '{1'b1, 3'b110, 32'd1,         32'h24,     32'd16,        1'b0};
    vecs[12] = '{1'b0, 3'b101, 32'hFFFFFFFF,  32'd1,      32'd0,         1'b1};
    vecs[13] = '{1'b1, 3'b111, 32'h80000000,  32'd31,     32'd1,         1'b0};

    // Reset state, with a request already pending to prove ready stays low in reset.
    idle_inputs();
    drive_req(1'b0, 1'b1, 3'b000, 32'd5, 32'd7);
    #2;
    checkBit("reset req0_ready", bus.req0_ready_o, 1'b0);
    checkBit("reset req1_ready", bus.req1_ready_o, 1'b0);
    checkBit("reset rsp0_valid", bus.rsp0_valid_o, 1'b0);
    checkBit("reset rsp1_valid", bus.rsp1_valid_o, 1'b0);
    checkBit("reset busy", bus.busy_o, 1'b0);
    checkBit("reset owner", bus.owner_o, 1'b0);
    checkOutput("reset alu_a", bus.alu_a_o, '0);
    checkOutput("reset alu_b", bus.alu_b_o, '0);
    checkOutput("reset alu_ctrl", WIDTH'(bus.alu_ctrl_o), '0);
    checkOutput("reset result", bus.rsp0_result_o, '0);
    @(negedge clk);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 3'b000, '0, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Tie on both arbiters: round-robin alternates, fixed priority keeps serving req0.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 3'b110, 32'd1, 32'd4);
    drive_req(1'b1, 1'b1, 3'b111, 32'h80, 32'd3);
    bus.rsp0_ready_i  = 1'b1; bus.rsp1_ready_i  = 1'b1;
    fbus.req0_valid_i = 1'b1; fbus.req0_op_i = 3'b110; fbus.req0_a_i = 32'd1;  fbus.req0_b_i = 32'd4;
    fbus.req1_valid_i = 1'b1; fbus.req1_op_i = 3'b111; fbus.req1_a_i = 32'h80; fbus.req1_b_i = 32'd3;
    fbus.rsp0_ready_i = 1'b1; fbus.rsp1_ready_i = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      checkBit($sformatf("tie%0d ready", k), ready_of(g), 1'b1);
      checkBit($sformatf("tie%0d other ready", k), ready_of(!g), 1'b0);
      checkBit($sformatf("fixed%0d ready0", k), fbus.req0_ready_o, 1'b1);
      checkBit($sformatf("fixed%0d ready1", k), fbus.req1_ready_o, 1'b0);
      @(negedge clk);
      #1;
      checkBit($sformatf("tie%0d owner", k), bus.owner_o, g);
      checkBit($sformatf("fixed%0d owner", k), fbus.owner_o, 1'b0);
      @(negedge clk);
      #1;
      checkBit($sformatf("tie%0d rsp_valid", k), rsp_valid_of(g), 1'b1);
      checkOutput($sformatf("tie%0d result", k), rsp_result_of(g), 32'd16);
      checkBit($sformatf("fixed%0d rsp0_valid", k), fbus.rsp0_valid_o, 1'b1);
      checkBit($sformatf("fixed%0d rsp1_valid", k), fbus.rsp1_valid_o, 1'b0);
      checkOutput($sformatf("fixed%0d result", k), fbus.rsp0_result_o, 32'd16);
      @(negedge clk);
      #1;
    end
    idle_inputs();

    // Back-pressure: result held while rsp0 stalls, req1 locked out until after the handshake.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 3'b100, 32'hFF, 32'h0F);
    #1;
    checkBit("bp accept", bus.req0_ready_o, 1'b1);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 3'b000, '0, '0);
    drive_req(1'b1, 1'b1, 3'b000, 32'd1, 32'd1);
    #1;
    checkBit("bp exec req1_ready", bus.req1_ready_o, 1'b0);
    @(negedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkBit($sformatf("bp%0d rsp0_valid", i), bus.rsp0_valid_o, 1'b1);
      checkOutput($sformatf("bp%0d result", i), bus.rsp0_result_o, 32'hF0);
      checkBit($sformatf("bp%0d req1_ready", i), bus.req1_ready_o, 1'b0);
      @(negedge clk);
      #1;
    end
    checkBit("bp release req1_ready", bus.req1_ready_o, 1'b0);
    bus.rsp0_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp0_ready_i = 1'b0;
    #1;
    checkBit("bp after req1_ready", bus.req1_ready_o, 1'b1);
    checkBit("bp after rsp0_valid", bus.rsp0_valid_o, 1'b0);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b000, '0, '0);
    @(negedge clk);
    #1;
    checkBit("bp req1 rsp_valid", bus.rsp1_valid_o, 1'b1);
    checkOutput("bp req1 result", bus.rsp1_result_o, 32'd2);
    bus.rsp1_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp1_ready_i = 1'b0;

    // Reset during EXEC discards the op and clears every output at once.
    @(negedge clk);
    drive_req(1'b1, 1'b1, 3'b111, 32'h11, 32'h22);
    #1;
    checkBit("rst accept", bus.req1_ready_o, 1'b1);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 3'b000, '0, '0);
    #1;
    checkOutput("rst exec alu_a", bus.alu_a_o, 32'h11);
    rst_n = 1'b0;
    #1;
    checkBit("rst busy", bus.busy_o, 1'b0);
    checkBit("rst owner", bus.owner_o, 1'b0);
    checkOutput("rst alu_a", bus.alu_a_o, '0);
    checkOutput("rst alu_b", bus.alu_b_o, '0);
    checkOutput("rst alu_ctrl", WIDTH'(bus.alu_ctrl_o), '0);
    checkOutput("rst result", bus.rsp1_result_o, '0);
    checkBit("rst rsp1_valid", bus.rsp1_valid_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkBit($sformatf("post-rst%0d rsp0_valid", i), bus.rsp0_valid_o, 1'b0);
      checkBit($sformatf("post-rst%0d rsp1_valid", i), bus.rsp1_valid_o, 1'b0);
      checkBit($sformatf("post-rst%0d busy", i), bus.busy_o, 1'b0);
    end
    v = '{1'b0, 3'b101, 32'd3, 32'd9, 32'd1, 1'b0};
    applyStimulus(v, "post-rst slt");

    // Operands changed after acceptance must not reach the ALU.
    @(negedge clk);
    drive_req(1'b0, 1'b1, 3'b000, 32'd2, 32'd3);
    #1;
    checkBit("iso accept", bus.req0_ready_o, 1'b1);
    @(negedge clk);
    drive_req(1'b0, 1'b0, 3'b001, 32'd100, 32'd50);
    #1;
    checkOutput("iso alu_a", bus.alu_a_o, 32'd2);
    @(negedge clk);
    #1;
    checkBit("iso rsp_valid", bus.rsp0_valid_o, 1'b1);
    checkOutput("iso result", bus.rsp0_result_o, 32'd5);
    bus.rsp0_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp0_ready_i = 1'b0;

    // Randomized traffic from a clean reset against the transaction-level model.
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    pend[0] = 1'b0; pend[1] = 1'b0;
    outstanding = 1'b0; out_owner = 1'b0; tie_winner = 1'b0; age = 0; out_res = '0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!pend[r]) begin
          if ($urandom_range(0, 1) == 1) begin
            pend[r] = 1'b1;
            rop[r]  = 3'($urandom_range(0, 7));
            ra[r]   = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
            rb[r]   = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
          end
        end else if ($urandom_range(0, 9) == 0) begin
          pend[r] = 1'b0;
        end
        rrdy[r] = ($urandom_range(0, 2) != 0);
        drive_req(r[0], pend[r], rop[r], ra[r], rb[r]);
        set_rsp_ready(r[0], rrdy[r]);
      end
      #1;
      exp_r[0] = 1'b0; exp_r[1] = 1'b0; w = 1'b0;
      if (!outstanding && (pend[0] || pend[1])) begin
        w = (pend[0] && pend[1]) ? tie_winner : pend[1];
        exp_r[w] = 1'b1;
      end
      checkBit("rand req0_ready", bus.req0_ready_o, exp_r[0]);
      checkBit("rand req1_ready", bus.req1_ready_o, exp_r[1]);
      checkBit("rand busy", bus.busy_o, outstanding);
      if (outstanding) begin
        checkBit("rand owner", bus.owner_o, out_owner);
      end
      if (outstanding && age >= 2) begin
        checkBit("rand rsp_valid", rsp_valid_of(out_owner), 1'b1);
        checkBit("rand other rsp_valid", rsp_valid_of(!out_owner), 1'b0);
        checkOutput("rand result", rsp_result_of(out_owner), out_res);
        checkBit("rand zero", rsp_zero_of(out_owner), (out_res == '0));
      end else begin
        checkBit("rand rsp0_valid", bus.rsp0_valid_o, 1'b0);
        checkBit("rand rsp1_valid", bus.rsp1_valid_o, 1'b0);
      end
      if (outstanding && age >= 2 && rrdy[out_owner]) begin
        outstanding = 1'b0;
        tie_winner  = !out_owner;
      end else if (outstanding) begin
        age++;
      end else if (pend[0] || pend[1]) begin
        outstanding = 1'b1;
        out_owner   = w;
        out_res     = alu_ref(rop[w], ra[w], rb[w]);
        age         = 1;
        pend[w]     = 1'b0;
      end
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
